// File: rtl/mem_request_unit.sv
// Sequences core load/store requests onto the single RAM data port, stalls
// fetch via pc_enable while an access is in flight, and handles sticky halt.
module mem_request_unit #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              dmem_read,
  input  logic              dmem_write,
  input  logic [31:0]       dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdata,
  input  logic              halt,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_ready,
  output logic              dmem_err,
  output logic              halted,
  output logic              pc_enable,
  output logic              ram_read_enable,
  output logic              ram_write_enable,
  output logic [ADDR_W-1:0] ram_address_DM,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, WR, RESP, HALT} state_t;

  localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

  state_t            state_q;
  logic [1:0]        cnt_q;
  logic              err_q;
  logic              hpend_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic req, legal, conflict;

  assign req      = dmem_read | dmem_write;
  assign conflict = dmem_read & dmem_write;
  assign legal    = (dmem_addr[1:0] == 2'b00) && (dmem_addr[31:ADDR_W+2] == '0);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      hpend_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (halt) begin
            state_q <= HALT;
          end else if (req) begin
            if (!legal || conflict) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
              state_q <= RESP;
            end else begin
              err_q   <= 1'b0;
              addr_q  <= dmem_addr[ADDR_W+1:2];
              wdata_q <= dmem_wdata;
              cnt_q   <= '0;
              state_q <= dmem_read ? RD_WAIT : WR;
            end
          end
        end
        RD_WAIT: begin
          if (halt) hpend_q <= 1'b1;
          if (cnt_q == CNT_LAST) begin
            rdata_q <= ram_data_out;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        WR: begin
          if (halt) hpend_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          // A halt seen at any point during the access wins once it completes.
          state_q <= (hpend_q || halt) ? HALT : IDLE;
          hpend_q <= 1'b0;
          err_q   <= 1'b0;
        end
        HALT:    state_q <= HALT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_read_enable  = (state_q == RD_WAIT);
  assign ram_write_enable = (state_q == WR);
  assign ram_address_DM   = addr_q;
  assign ram_data_in      = wdata_q;
  assign dmem_rdata       = rdata_q;
  assign dmem_ready       = (state_q == RESP);
  assign dmem_err         = (state_q == RESP) && err_q;
  assign halted           = (state_q == HALT);
  // Fetch stalls on the acceptance cycle itself; forced low while in reset.
  assign pc_enable        = nRst && (((state_q == IDLE) && !req && !halt) ||
                                     (state_q == RESP));

endmodule

// File: doc/mem_request_unit.md
Name: mem_request_unit

Overview:
- Sits directly upstream of the unified instruction/data RAM and sequences core data-memory requests onto its single data port.
- Generates `pc_enable`, which gates instruction fetch so the core stalls while a load or store is in flight.
- Converts 32-bit byte addresses from the core into RAM word addresses and flags illegal accesses.
- Latches load data and returns it with a one-cycle ready pulse.

Parameters:
- ADDR_W, 5, RAM word-address width (RAM depth = 2^ADDR_W words)
- DATA_W, 32, data word width
- RD_LAT, 1, RAM read latency in cycles from address/read_enable to valid data_out; legal range 1..3

Ports:
- clk  input  1  system clock, rising edge
- nRst  input  1  asynchronous active-low reset
- dmem_read  input  1  core load request, held until dmem_ready
- dmem_write  input  1  core store request, held until dmem_ready
- dmem_addr  input  32  core byte address
- dmem_wdata  input  DATA_W  store data
- halt  input  1  core halt request
- dmem_rdata  output  DATA_W  registered load data
- dmem_ready  output  1  one-cycle completion pulse
- dmem_err  output  1  one-cycle error pulse, coincident with dmem_ready
- halted  output  1  sticky halt indicator
- pc_enable  output  1  advance PC / fetch enable to the core and RAM
- ram_read_enable  output  1  RAM data-port read strobe
- ram_write_enable  output  1  RAM data-port write strobe
- ram_address_DM  output  ADDR_W  RAM data word address
- ram_data_in  output  DATA_W  RAM write data
- ram_data_out  input  DATA_W  RAM read data

Behaviour:
- Reset is asynchronous and active-low, on `nRst`; all state updates on the rising edge of `clk`.
- Reset values: state = IDLE, all outputs 0 (including `pc_enable` and `halted`), latency counter 0.
- FSM states: IDLE, RD_WAIT, WR, RESP, HALT.
- IDLE, no request and no halt: `pc_enable` = 1 every cycle (one instruction per cycle).
- IDLE acceptance: on a cycle with `dmem_read` or `dmem_write` asserted, latch the address, write data and operation; `pc_enable` = 0 that cycle.
- Address legality: `dmem_addr[1:0]` == 0 and `dmem_addr[31:ADDR_W+2]` == 0.
  - Word address = `dmem_addr[ADDR_W+1:2]`.
- Illegal address, or `dmem_read` and `dmem_write` both high: no RAM strobe; go to RESP with err set and `dmem_rdata` = 0.
- Legal read: go to RD_WAIT.
  - Drive `ram_read_enable` = 1 and `ram_address_DM` for RD_LAT cycles; the counter counts 0..RD_LAT-1.
  - On the final count, register `ram_data_out` into `dmem_rdata`, then go to RESP.
- Legal write: go to WR.
  - `ram_write_enable` = 1 for exactly one cycle with the latched address and data, then go to RESP.
- RESP (one cycle): `dmem_ready` = 1, `dmem_err` as latched, `pc_enable` = 1.
  - Next state: HALT if a halt is pending, else IDLE.
- Request-to-ready latency:
  - Load: RD_LAT+2 cycles (RD_LAT = 1 gives 3).
  - Store: 2 cycles after acceptance.
  - Error: 1 cycle after acceptance.
- RAM strobes are never asserted outside RD_WAIT/WR; `ram_address_DM` and `ram_data_in` hold their last value when idle.
- `dmem_rdata` holds its value until the next completed load; a store does not change it.
- The core must drop its request in the cycle after `dmem_ready`. A request still high in the IDLE cycle after RESP is treated as a new request.
- Halt:
  - In IDLE, a halt goes to HALT immediately.
  - During RD_WAIT, WR or RESP, the halt is recorded and the current operation completes first.
  - In HALT: `halted` = 1, `pc_enable` = 0, all requests ignored; only reset exits.
- Reset mid-operation: the async clear aborts the access; the RAM strobes drop immediately (combinational from state); no ready is issued.

Test Plan:
- Reset, then idle 4 cycles -> all outputs 0 while `nRst` low; `pc_enable` = 1 for all 4 cycles after release, no RAM strobes.
- Store 0xDEADBEEF to 0x0000000C -> `ram_write_enable` high for 1 cycle with `ram_address_DM` = 3 and `ram_data_in` = 0xDEADBEEF; `dmem_ready` 2 cycles after acceptance; `pc_enable` low for exactly 2 cycles.
- Load from 0x0000000C with RD_LAT = 1 after that store -> `dmem_rdata` = 0xDEADBEEF with `dmem_ready` on cycle 3. Repeat with RD_LAT = 3 -> ready on cycle 5, `ram_read_enable` high for 3 cycles.
- Load from 0x0000000E (misaligned) and from 0x00000080 (out of range) -> no RAM strobe, `dmem_ready` = `dmem_err` = 1 one cycle after acceptance, `dmem_rdata` = 0.
- Halt asserted during RD_WAIT of a load from address 0x4 -> load completes with correct data, then `halted` = 1 and `pc_enable` = 0; a subsequent `dmem_write` produces no `ram_write_enable`.
- `nRst` pulsed low mid-RD_WAIT -> strobes drop the same cycle, no `dmem_ready`; after release `pc_enable` = 1 and a new load completes normally.
